// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for seq_alu and its iterative
// multiply/divide unit.
//   alu_op_e    - 3-bit opcode carried on the select input
//   alu_state_e - seq_alu control states
//   FLAG_*      - bit positions inside the optional flags output
//                 (present only when SEQ_ALU_FLAGS_EN is defined)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SLT  = 3'b100,
    OP_MUL  = 3'b101,
    OP_DIVU = 3'b110,
    OP_REMU = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  function automatic logic is_iter_op(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle multiply (low half) and unsigned
// restoring divide/remainder.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands a/b and arm the WIDTH-iteration counter
//   op         : operation for the running iterations (held by the caller)
//   a, b       : operands, sampled only on start
//   busy       : iterations still outstanding
//   done       : this cycle performs the final iteration; res is valid now
//   res        : value after the current iteration (product, quotient or
//                remainder, chosen by op)
// The same three registers serve both algorithms:
//   MUL  : acc = partial product, opa = shifted multiplicand, opb = multiplier
//   DIV  : acc = partial remainder, opa = dividend -> quotient, opb = divisor
// A zero divisor needs no special case: every trial subtraction succeeds,
// giving an all-ones quotient, and the dividend shifts intact into acc.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, opa, opb;
  logic [WIDTH-1:0] acc_nxt, opa_nxt, opb_nxt;
  logic [WIDTH:0]   trial;

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));

  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    trial   = '0;
    if (op == OP_MUL) begin
      if (opb[0]) acc_nxt = acc + opa;
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end else begin
      trial = {acc, opa[WIDTH-1]} - {1'b0, opb};
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        opa_nxt = {opa[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[WIDTH-2:0], opa[WIDTH-1]};
        opa_nxt = {opa[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign res = (op == OP_DIVU) ? opa_nxt : acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      opa <= '0;
      opb <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      acc <= '0;
      opa <= a;
      opb <= b;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      acc <= acc_nxt;
      opa <= opa_nxt;
      opb <= opb_nxt;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operation request / acceptance (accept = both high)
//   A, B, select        : operands and opcode (alu_op_e encoding)
//   out_valid/out_ready : result offer / consumption
//   result              : registered result, held while in DONE
//   flags               : {zero, negative, overflow}, only with SEQ_ALU_FLAGS_EN
// Single-cycle ops register their result on the accept edge; MUL/DIVU/REMU
// run WIDTH iterations in alu_muldiv_iter first.
//
// state | meaning
// IDLE  | ready for a new operation
// BUSY  | iterative op in progress
// DONE  | result offered, waiting for out_ready
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  alu_state_e       state, state_nxt;
  alu_op_e          op_in, op_q;
  logic             start, load_sc, load_it;
  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_res, sc_res;

  assign op_in = alu_op_e'(select);

  always_comb begin
    sc_res = '0;
    case (op_in)
      OP_ADD:  sc_res = A + B;
      OP_SUB:  sc_res = A - B;
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: sc_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start     = 1'b0;
    load_sc   = 1'b0;
    load_it   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_iter_op(op_in)) begin
            start     = 1'b1;
            state_nxt = BUSY;
          end else begin
            load_sc   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          load_it   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_ADD;
      result <= '0;
    end else begin
      if (in_valid && in_ready) op_q <= op_in;
      if (load_sc)      result <= sc_res;
      else if (load_it) result <= md_res;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (start ? op_in : op_q),
    .a     (A),
    .b     (B),
    .busy  (md_busy),
    .done  (md_done),
    .res   (md_res)
  );

`ifdef SEQ_ALU_FLAGS_EN
  logic ovf;

  // Signed overflow: ADD with same-sign operands, SUB with opposite-sign
  // operands, and the result sign differs from A.
  always_comb begin
    ovf = 1'b0;
    if (op_in == OP_ADD)
      ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
    else if (op_in == OP_SUB)
      ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (load_sc) begin
      flags[FLAG_ZERO] <= (sc_res == '0);
      flags[FLAG_NEG]  <= sc_res[WIDTH-1];
      flags[FLAG_OVF]  <= ovf;
    end else if (load_it) begin
      flags[FLAG_ZERO] <= (md_res == '0);
      flags[FLAG_NEG]  <= md_res[WIDTH-1];
      flags[FLAG_OVF]  <= 1'b0;
    end
  end
`endif

endmodule
